uart_cfg_ctrl: RTL

UART_CFG_CTRL -- requirements
Module: uart_cfg_ctrl

---
 rtl/uart_cfg_ctrl_if.sv | 15 +
 rtl/uart_cfg_ctrl.sv | 252 +++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_cfg_ctrl_if.sv
// Register-file request/response bus between the UART profile controller
// (master) and the register file (slave).
interface uart_cfg_ctrl_if;
  logic       valid;
  logic [3:0] address;
  logic [3:0] data;
  logic       ack;
  logic       data_out_valid;
  logic [3:0] data_out;

  modport master (output valid, address, data,
                  input  ack, data_out_valid, data_out);
  modport slave  (input  valid, address, data,
                  output ack, data_out_valid, data_out);
endinterface

// File: rtl/uart_cfg_ctrl.sv
// UART profile controller: writes, reads back or restores the 4-register UART profile.
// Optional feature: define UART_CFG_VERIFY_EN to chain a readback + compare after a write.
module uart_cfg_ctrl #(
  parameter int unsigned TIMEOUT = 15
) (
  input  logic            clk_16bd,
  input  logic            rst_n,
  input  logic            start,
  input  logic [1:0]      op,
  input  logic            parity_in,
  input  logic            parity_type_in,
  input  logic            stop_bits_in,
  input  logic [3:0]      frame_length_in,
  uart_cfg_ctrl_if.master bus,
  output logic            busy,
  output logic            done,
  output logic            error,
  output logic            rb_parity,
  output logic            rb_parity_type,
  output logic            rb_stop_bits,
  output logic [3:0]      rb_frame_length
);

  typedef enum logic [1:0] {S_IDLE, S_REQ, S_GAP, S_FIN} state_t;

  localparam logic [1:0] OP_WR  = 2'b00;
  localparam logic [1:0] OP_RD  = 2'b01;
  localparam logic [1:0] OP_RST = 2'b10;
  localparam logic [7:0] WAIT_LAST = 8'(TIMEOUT - 1);
  localparam logic [3:0] RD_DATA = 4'b1111;

  state_t     state_q, state_d;
  logic [1:0] idx_q, idx_d;
  logic [7:0] wcnt_q, wcnt_d;
  logic [1:0] mode_q, mode_d;
  logic       par_q, par_d, pty_q, pty_d, stp_q, stp_d;
  logic [3:0] fl_q, fl_d;
  logic       valid_q, valid_d;
  logic [3:0] addr_q, addr_d, data_q, data_d;
  logic       busy_q, busy_d, done_q, done_d, err_q, err_d;
  logic       rbp_q, rbp_d, rbt_q, rbt_d, rbs_q, rbs_d;
  logic [3:0] rbf_q, rbf_d;
`ifdef UART_CFG_VERIFY_EN
  logic       chain_q, chain_d;
  logic       mismatch;
`endif

  logic accept, bad_cmd, last_idx;
  assign accept   = (state_q == S_IDLE) && start;
  assign bad_cmd  = (op == 2'b11) || ((op == OP_WR) && (frame_length_in == 4'hF));
  assign last_idx = (idx_q == 2'd3);
`ifdef UART_CFG_VERIFY_EN
  assign mismatch = {rbp_q, rbt_q, rbs_q, rbf_q} != {par_q, pty_q, stp_q, fl_q};
`endif

  function automatic logic [3:0] addr_of(input logic [1:0] i);
    return 4'd9 + {2'b00, i};
  endfunction

  function automatic logic [3:0] wr_data(input logic [1:0] i, input logic p, input logic t,
                                         input logic s, input logic [3:0] f);
    case (i)
      2'd0:    return {3'b000, p};
      2'd1:    return {3'b000, t};
      2'd2:    return {3'b000, s};
      default: return f;
    endcase
  endfunction

  always_ff @(posedge clk_16bd or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      idx_q   <= '0;
      wcnt_q  <= '0;
      mode_q  <= '0;
      par_q   <= 1'b0;
      pty_q   <= 1'b0;
      stp_q   <= 1'b0;
      fl_q    <= '0;
      valid_q <= 1'b0;
      addr_q  <= '0;
      data_q  <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
      rbp_q   <= 1'b1;
      rbt_q   <= 1'b0;
      rbs_q   <= 1'b0;
      rbf_q   <= 4'b1000;
`ifdef UART_CFG_VERIFY_EN
      chain_q <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      wcnt_q  <= wcnt_d;
      mode_q  <= mode_d;
      par_q   <= par_d;
      pty_q   <= pty_d;
      stp_q   <= stp_d;
      fl_q    <= fl_d;
      valid_q <= valid_d;
      addr_q  <= addr_d;
      data_q  <= data_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      err_q   <= err_d;
      rbp_q   <= rbp_d;
      rbt_q   <= rbt_d;
      rbs_q   <= rbs_d;
      rbf_q   <= rbf_d;
`ifdef UART_CFG_VERIFY_EN
      chain_q <= chain_d;
`endif
    end
  end

  // Sequencing: state, transaction index and ack wait counter.
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    wcnt_d  = wcnt_q;
    case (state_q)
      S_IDLE: if (accept) begin
        idx_d   = '0;
        wcnt_d  = '0;
        state_d = bad_cmd ? S_FIN : S_REQ;
      end
      S_REQ: begin
        if (mode_q == OP_RST)          state_d = S_FIN;
        else if (bus.ack)              state_d = S_GAP;
        else if (wcnt_q == WAIT_LAST)  state_d = S_FIN;
        else                           wcnt_d  = wcnt_q + 8'd1;
      end
      S_GAP: begin
        wcnt_d = '0;
        if (!last_idx) begin
          idx_d   = idx_q + 2'd1;
          state_d = S_REQ;
        end else begin
`ifdef UART_CFG_VERIFY_EN
          if (mode_q == OP_WR) begin
            idx_d   = '0;
            state_d = S_REQ;
          end else begin
            state_d = S_FIN;
          end
`else
          state_d = S_FIN;
`endif
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Registered outputs, profile latch and readback capture.
  always_comb begin
    mode_d  = mode_q;
    par_d   = par_q;
    pty_d   = pty_q;
    stp_d   = stp_q;
    fl_d    = fl_q;
    valid_d = valid_q;
    addr_d  = addr_q;
    data_d  = data_q;
    done_d  = 1'b0;
    err_d   = err_q;
    rbp_d   = rbp_q;
    rbt_d   = rbt_q;
    rbs_d   = rbs_q;
    rbf_d   = rbf_q;
    busy_d  = (state_d != S_IDLE);
`ifdef UART_CFG_VERIFY_EN
    chain_d = chain_q;
`endif
    case (state_q)
      S_IDLE: if (accept) begin
        mode_d = op;
        par_d  = parity_in;
        pty_d  = parity_type_in;
        stp_d  = stop_bits_in;
        fl_d   = frame_length_in;
        err_d  = bad_cmd;
`ifdef UART_CFG_VERIFY_EN
        chain_d = 1'b0;
`endif
        if (!bad_cmd) begin
          valid_d = 1'b1;
          case (op)
            OP_RST:  begin addr_d = 4'b0000; data_d = 4'b0000; end
            OP_RD:   begin addr_d = addr_of(2'd0); data_d = RD_DATA; end
            default: begin addr_d = addr_of(2'd0); data_d = {3'b000, parity_in}; end
          endcase
        end
      end
      S_REQ: begin
        if (mode_q == OP_RST) begin
          valid_d = 1'b0;
        end else if (bus.ack) begin
          valid_d = 1'b0;
          if ((mode_q == OP_RD) && bus.data_out_valid) begin
            case (idx_q)
              2'd0:    rbp_d = bus.data_out[0];
              2'd1:    rbt_d = bus.data_out[0];
              2'd2:    rbs_d = bus.data_out[0];
              default: rbf_d = bus.data_out;
            endcase
          end
        end else if (wcnt_q == WAIT_LAST) begin
          valid_d = 1'b0;
          err_d   = 1'b1;
        end
      end
      S_GAP: begin
        if (!last_idx) begin
          valid_d = 1'b1;
          addr_d  = addr_of(idx_q + 2'd1);
          data_d  = (mode_q == OP_RD) ? RD_DATA
                                      : wr_data(idx_q + 2'd1, par_q, pty_q, stp_q, fl_q);
        end else begin
`ifdef UART_CFG_VERIFY_EN
          // Write finished: turn around into a readback of the same profile.
          if (mode_q == OP_WR) begin
            mode_d  = OP_RD;
            chain_d = 1'b1;
            valid_d = 1'b1;
            addr_d  = addr_of(2'd0);
            data_d  = RD_DATA;
          end else if (chain_q && mismatch) begin
            err_d = 1'b1;
          end
`endif
        end
      end
      S_FIN:   done_d = 1'b1;
      default: ;
    endcase
  end

  assign bus.valid       = valid_q;
  assign bus.address     = addr_q;
  assign bus.data        = data_q;
  assign busy            = busy_q;
  assign done            = done_q;
  assign error           = err_q;
  assign rb_parity       = rbp_q;
  assign rb_parity_type  = rbt_q;
  assign rb_stop_bits    = rbs_q;
  assign rb_frame_length = rbf_q;

endmodule
